// File: rtl/core_pkg.sv
// Shared RV32I core definitions: writeback source encoding, load funct3 codes
// and the MEM/WB pipeline register layout.
package core_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_LOAD = 2'b01,
      RES_PC4  = 2'b10
   } resultsrc_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // resultsrc kept as raw bits so the reserved 2'b11 code can be held as-is
   typedef struct packed {
      logic              valid;
      logic              regwrite;
      logic [4:0]        rd;
      logic [1:0]        resultsrc;
      logic [2:0]        funct3;
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] load_word;
      logic [DATA_W-1:0] pc_plus4;
   } memwb_t;

endpackage

// File: rtl/load_formatter.sv
// Combinational load data formatter: extracts and extends a byte/half/word
// from an aligned memory word and flags misaligned half/word accesses.
module load_formatter
   import core_pkg::*;
(
   input  logic [DATA_W-1:0] i_word,
   input  logic [1:0]        i_off,
   input  logic [2:0]        i_funct3,
   output logic [DATA_W-1:0] o_data,
   output logic              o_misalign
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_word[{i_off, 3'b000} +: 8];
   assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

   // NOTE: o_data gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      o_data = i_word;
      case (i_funct3)
         F3_LB:   o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
         F3_LBU:  o_data = {{(DATA_W-8){1'b0}}, w_byte};
         F3_LH:   o_data = {{(DATA_W-16){w_half[15]}}, w_half};
         F3_LHU:  o_data = {{(DATA_W-16){1'b0}}, w_half};
         default: o_data = i_word;
      endcase
   end

   assign o_misalign = (((i_funct3 == F3_LH) || (i_funct3 == F3_LHU)) && i_off[0])
                     || ((i_funct3 == F3_LW) && (i_off != 2'b00));

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback mux; drives the register file write
// port, writeback forwarding info and the retired-instruction counter.
module wb_stage
   import core_pkg::*;
#(
   parameter int XLEN  = DATA_W,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             m_valid,
   input  logic             m_regwrite,
   input  logic [4:0]       m_rd,
   input  logic [1:0]       m_resultsrc,
   input  logic [2:0]       m_funct3,
   input  logic [XLEN-1:0]  m_alu_result,
   input  logic [XLEN-1:0]  m_load_word,
   input  logic [XLEN-1:0]  m_pc_plus4,
   input  logic             stall_w,
   input  logic             flush_w,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [XLEN-1:0]  rf_wdata,
   output logic             w_fwd_valid,
   output logic [4:0]       w_fwd_rd,
   output logic             load_misalign,
   output logic [CNT_W-1:0] retire_cnt
);

   memwb_t           r_mw;
   memwb_t           w_in;
   logic [CNT_W-1:0] r_retire_cnt;
   logic [XLEN-1:0]  w_load_data;
   logic             w_fmt_misalign;
   logic             w_misalign;

   assign w_in = '{valid:      m_valid,
                   regwrite:   m_regwrite,
                   rd:         m_rd,
                   resultsrc:  m_resultsrc,
                   funct3:     m_funct3,
                   alu_result: m_alu_result,
                   load_word:  m_load_word,
                   pc_plus4:   m_pc_plus4};

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mw <= '0;
      end else if (flush_w) begin
         r_mw <= '0;
      end else if (!stall_w) begin
         r_mw <= w_in;
      end
   end

   load_formatter u_load_formatter (
      .i_word     (r_mw.load_word),
      .i_off      (r_mw.alu_result[1:0]),
      .i_funct3   (r_mw.funct3),
      .o_data     (w_load_data),
      .o_misalign (w_fmt_misalign)
   );

   assign w_misalign = r_mw.valid && (r_mw.resultsrc == RES_LOAD) && w_fmt_misalign;

   always_comb begin
      rf_wdata = r_mw.alu_result;
      case (r_mw.resultsrc)
         RES_LOAD: rf_wdata = w_load_data;
         RES_PC4:  rf_wdata = r_mw.pc_plus4;
         default:  rf_wdata = r_mw.alu_result;
      endcase
   end

   // An instruction retires when it leaves WB; faulting loads are not counted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_retire_cnt <= '0;
      end else if (r_mw.valid && !stall_w && !w_misalign) begin
         r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
   end

   assign rf_we         = r_mw.valid && r_mw.regwrite && (r_mw.rd != 5'd0) && !w_misalign;
   assign rf_waddr      = r_mw.rd;
   assign w_fwd_valid   = rf_we;
   assign w_fwd_rd      = r_mw.rd;
   assign load_misalign = w_misalign;
   assign retire_cnt    = r_retire_cnt;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a driver feeds directed and random MEM-stage
// traffic and queues expected writeback outputs; a monitor pops and compares.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m_valid = 1'b0, m_regwrite = 1'b0;
   logic [4:0]  m_rd = '0;
   logic [1:0]  m_resultsrc = '0;
   logic [2:0]  m_funct3 = '0;
   logic [31:0] m_alu_result = '0, m_load_word = '0, m_pc_plus4 = '0;
   logic        stall_w = 1'b0, flush_w = 1'b0;
   logic        rf_we, w_fwd_valid, load_misalign;
   logic [4:0]  rf_waddr, w_fwd_rd;
   logic [31:0] rf_wdata, retire_cnt;

   wb_stage #(.XLEN(32), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_valid(m_valid), .m_regwrite(m_regwrite), .m_rd(m_rd),
      .m_resultsrc(m_resultsrc), .m_funct3(m_funct3),
      .m_alu_result(m_alu_result), .m_load_word(m_load_word), .m_pc_plus4(m_pc_plus4),
      .stall_w(stall_w), .flush_w(flush_w),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .w_fwd_valid(w_fwd_valid), .w_fwd_rd(w_fwd_rd),
      .load_misalign(load_misalign), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        mis;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   logic mon_en = 1'b0;

   // Reference model: the instruction sitting in WB, plus the retire count
   logic        md_valid, md_regwrite;
   logic [4:0]  md_rd;
   logic [1:0]  md_src;
   logic [2:0]  md_f3;
   logic [31:0] md_alu, md_word, md_pc, md_cnt;

   task automatic model_clear();
      md_valid = 0; md_regwrite = 0; md_rd = 0; md_src = 0; md_f3 = 0;
      md_alu = 0; md_word = 0; md_pc = 0;
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] word, input int off,
                                              input logic [2:0] f3);
      int unsigned b, h;
      b = (word >> (8 * off)) & 32'hFF;
      h = (word >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd4:    return b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd5:    return h;
         default: return word;
      endcase
   endfunction

   function automatic logic model_mis();
      int off;
      off = int'(md_alu % 4);
      return md_valid && (md_src == 2'd1) &&
             ((((md_f3 == 3'd1) || (md_f3 == 3'd5)) && (off % 2 == 1)) ||
              ((md_f3 == 3'd2) && (off != 0)));
   endfunction

   task automatic model_step(input logic v, rw, input logic [4:0] rd, input logic [1:0] src,
                             input logic [2:0] f3, input logic [31:0] alu, word, pc,
                             input logic st, fl);
      exp_t e;
      if (md_valid && !st && !model_mis()) md_cnt = md_cnt + 1;
      if (fl) model_clear();
      else if (!st) begin
         md_valid = v; md_regwrite = rw; md_rd = rd; md_src = src; md_f3 = f3;
         md_alu = alu; md_word = word; md_pc = pc;
      end
      e.mis   = model_mis();
      e.we    = md_valid && md_regwrite && (md_rd != 0) && !e.mis;
      e.waddr = md_rd;
      e.wdata = (md_src == 2'd1) ? model_load(md_word, int'(md_alu % 4), md_f3) :
                (md_src == 2'd2) ? md_pc : md_alu;
      e.cnt   = md_cnt;
      sb_q.push_back(e);
   endtask

   task automatic cycle(input logic v, rw, input logic [4:0] rd, input logic [1:0] src,
                        input logic [2:0] f3, input logic [31:0] alu, word, pc,
                        input logic st, fl);
      @(negedge clk);
      m_valid = v; m_regwrite = rw; m_rd = rd; m_resultsrc = src; m_funct3 = f3;
      m_alu_result = alu; m_load_word = word; m_pc_plus4 = pc;
      stall_w = st; flush_w = fl;
      mon_en = 1'b1;
      model_step(v, rw, rd, src, f3, alu, word, pc, st, fl);
   endtask

   // Monitor: one expected entry per clock while enabled
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            if (sb_q.size() == 0) begin
               check("sb_underflow", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("rf_we",         {31'd0, rf_we},         {31'd0, e.we});
               check("w_fwd_valid",   {31'd0, w_fwd_valid},   {31'd0, e.we});
               check("rf_waddr",      {27'd0, rf_waddr},      {27'd0, e.waddr});
               check("w_fwd_rd",      {27'd0, w_fwd_rd},      {27'd0, e.waddr});
               check("load_misalign", {31'd0, load_misalign}, {31'd0, e.mis});
               check("retire_cnt",    retire_cnt,             e.cnt);
               if (!e.mis) check("rf_wdata", rf_wdata, e.wdata);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   localparam logic [31:0] LW_DATA = 32'h80F7_7F01;

   initial begin
      // Reset and idle
      #12;
      check("rst_rf_we",    {31'd0, rf_we}, 32'd0);
      check("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
      check("rst_rf_wdata", rf_wdata, 32'd0);
      check("rst_misalign", {31'd0, load_misalign}, 32'd0);
      check("rst_retire",   retire_cnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset asserted while x5 = 0x1234 is being written
      @(negedge clk);
      m_valid = 1; m_regwrite = 1; m_rd = 5'd5; m_resultsrc = 2'd0; m_alu_result = 32'h1234;
      @(posedge clk);
      #1;
      check("x5_we",    {31'd0, rf_we}, 32'd1);
      check("x5_waddr", {27'd0, rf_waddr}, 32'd5);
      check("x5_wdata", rf_wdata, 32'h1234);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_we",    {31'd0, rf_we}, 32'd0);
      check("midrst_wdata", rf_wdata, 32'd0);
      check("midrst_retire", retire_cnt, 32'd0);
      @(negedge clk);
      m_valid = 0; m_regwrite = 0; m_rd = 0; m_alu_result = 0;
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      md_cnt = 0;

      // ALU writes to x7 and x0
      cycle(1, 1, 5'd7, 2'd0, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 0);
      cycle(1, 1, 5'd0, 2'd0, 3'd0, 32'h55,        32'h0, 32'h0, 0, 0);
      // Load formatting
      cycle(1, 1, 5'd3, 2'd1, 3'd0, 32'h1003, LW_DATA, 32'h0, 0, 0);
      cycle(1, 1, 5'd3, 2'd1, 3'd4, 32'h1003, LW_DATA, 32'h0, 0, 0);
      cycle(1, 1, 5'd3, 2'd1, 3'd1, 32'h1002, LW_DATA, 32'h0, 0, 0);
      cycle(1, 1, 5'd3, 2'd1, 3'd5, 32'h1000, LW_DATA, 32'h0, 0, 0);
      cycle(1, 1, 5'd3, 2'd1, 3'd2, 32'h1000, LW_DATA, 32'h0, 0, 0);
      // Misaligned LW and LH
      cycle(1, 1, 5'd4, 2'd1, 3'd2, 32'h102, LW_DATA, 32'h0, 0, 0);
      cycle(1, 1, 5'd4, 2'd1, 3'd1, 32'h101, LW_DATA, 32'h0, 0, 0);
      // JAL link write
      cycle(1, 1, 5'd1, 2'd2, 3'd0, 32'h1234, 32'h0, 32'h44, 0, 0);
      // Stall for three cycles with new inputs, then release
      cycle(1, 1, 5'd9, 2'd0, 3'd0, 32'h99, 32'h0, 32'h0, 0, 0);
      for (int i = 0; i < 3; i++)
         cycle(1, 1, 5'(10 + i), 2'd0, 3'd0, $urandom, $urandom, $urandom, 1, 0);
      cycle(1, 1, 5'd13, 2'd0, 3'd0, 32'hABCD, 32'h0, 32'h0, 0, 0);
      // Stall and flush together: flush wins
      cycle(1, 1, 5'd14, 2'd0, 3'd0, 32'h77, 32'h0, 32'h0, 1, 1);
      cycle(0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
               $urandom, $urandom, $urandom,
               $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      end
      cycle(0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 0, 0);

      @(posedge clk);
      #2 mon_en = 1'b0;
      if (sb_q.size() != 0) check("sb_drain", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the 5-stage RV32I core; the write-side driver of the register file.
- Captures MEM-stage results at posedge clk, selects and formats the writeback value (ALU result, load data, PC+4), and drives the register file write port.
- Outputs are stable from posedge to the register file's negedge write, so ID reads the new value in the same cycle.
- Also exports writeback forwarding info for the hazard unit and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width
- CNT_W, 32, width of retire counter

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- m_valid  in  1  MEM stage holds a real instruction
- m_regwrite  in  1  instruction writes rd
- m_rd  in  5  destination register
- m_resultsrc  in  2  00=ALU, 01=load, 10=PC+4, 11=reserved (treated as ALU)
- m_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- m_alu_result  in  XLEN  ALU result / load address
- m_load_word  in  XLEN  aligned 32-bit word read from data memory
- m_pc_plus4  in  XLEN  PC+4 for JAL/JALR
- stall_w  in  1  hold MEM/WB register
- flush_w  in  1  load bubble into MEM/WB register
- rf_we  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  XLEN  register file write data
- w_fwd_valid  out  1  equals rf_we; forwarding qualifier
- w_fwd_rd  out  5  equals rf_waddr
- load_misalign  out  1  registered instruction is a misaligned load
- retire_cnt  out  CNT_W  count of retired instructions

Behaviour:
- Reset (async, rst_n=0): all MEM/WB fields cleared. valid=0, rd=0, result fields 0, retire_cnt=0. Therefore rf_we=0, rf_waddr=0, rf_wdata=0, load_misalign=0.
- Reset asserted mid-operation: the in-flight instruction is discarded. No write occurs after rst_n falls.
- Pipeline register update at posedge clk, in priority order:
  - flush_w: valid<=0 and regwrite<=0; other fields don't-care but cleared to 0.
  - else stall_w: hold all fields.
  - else capture all m_* inputs.
- flush_w and stall_w both high: flush wins.
- Latency: exactly one cycle from m_* sampled to rf_* outputs.
- rf_we = valid & regwrite & (rd != 0) & ~load_misalign. Writes to x0 are never issued; rf_waddr still reflects rd.
- Outputs while stalled: the held instruction's rf_we stays asserted. A rewrite of the same value is harmless and required for forwarding consistency.
- rf_wdata is combinational from registered fields:
  - 00/11 -> alu_result.
  - 10 -> pc_plus4.
  - 01 -> load formatting, with off = alu_result[1:0]:
    - LB/LBU: byte at bits [8*off+7 : 8*off], sign- or zero-extended.
    - LH/LHU: half at off[1] (bits [15:0] or [31:16]), sign- or zero-extended.
    - LW: full word.
  - Undefined funct3 on load: full word.
- load_misalign = valid & resultsrc==01 & ((LH|LHU & off[0]) | (LW & off!=0)). When set, rf_we=0 and rf_wdata is don't-care.
- retire_cnt: increments by 1 at posedge when valid=1 and stall_w=0, i.e. the instruction leaves WB. Misaligned loads do not count. Wraps modulo 2^CNT_W silently.

Decomposition:
- Shared core package (core_pkg):
  - resultsrc_e enum (RES_ALU, RES_LOAD, RES_PC4).
  - load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - memwb_t struct: valid, regwrite, rd, resultsrc, funct3, alu_result, load_word, pc_plus4.
- One sub-module: load_formatter (combinational: word, offset, funct3 -> formatted data and misalign flag). It is reused later by the store-side byte-lane logic's verification.

Test Plan:
- Reset then idle -> rf_we=0, rf_wdata=0, retire_cnt=0. Deassert rst_n mid-write of x5=0x1234 -> write disappears immediately, x5 unchanged.
- ALU writes x7=0xDEADBEEF, then x0=0x55 -> cycle 1: rf_we=1, waddr=7, wdata=0xDEADBEEF. Cycle 2: rf_we=0. retire_cnt=2.
- Load word 0x80F7_7F01:
  - LB off=3 -> 0xFFFFFF80.
  - LBU off=3 -> 0x00000080.
  - LH off=2 -> 0xFFFF80F7.
  - LHU off=0 -> 0x00007F01.
  - LW off=0 -> 0x80F77F01.
- Misaligned LW at address 0x102 and LH at 0x101 -> load_misalign=1, rf_we=0, retire_cnt unchanged.
- JAL with pc_plus4=0x0000_0044, rd=1 -> wdata=0x44, w_fwd_rd=1.
- stall_w held 3 cycles with new m_* inputs -> outputs held, retire_cnt +0. Simultaneous stall_w and flush_w -> bubble (rf_we=0).
